// File: rtl/argmax_pkg.sv
// Shared constants and types for the argmax classification stage.
// M values per frame, T-bit signed data, IDXW-bit index into the frame.
// res_t bundles one result (index + value) for the output holding register.
package argmax_pkg;

  localparam int M    = 6;
  localparam int T    = 16;
  localparam int IDXW = $clog2(M);

  typedef logic signed [T-1:0] val_t;
  typedef logic [IDXW-1:0]     idx_t;

  typedef struct packed {
    idx_t idx;
    val_t val;
  } res_t;

  // Position of the final element in a frame.
  localparam idx_t LAST_IDX = idx_t'(M - 1);

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register for one argmax result.
// Latency: 1 cycle from load to full. Backpressure: contents held while full && !drain.
// Ports: clk, reset (async active-low), load/next_res (write), drain (downstream ready),
//        full (entry valid), res (held result).
module stream_out_reg
  import argmax_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  res_t next_res,
  input  logic drain,
  output logic full,
  output res_t res
);

  // A load on the same edge as a drain wins: the entry is replaced and stays full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      res  <= '0;
    end else if (load) begin
      full <= 1'b1;
      res  <= next_res;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/argmax_6_16.sv
// Streaming argmax over frames of M signed T-bit values; one (index, max) result per frame.
// Latency: result valid the cycle after the last element is accepted; one frame per M cycles.
// Backpressure: elements 0..M-2 always accepted; only the last element stalls on a pending result.
// Ports: clk, reset (async active-low), s_valid/s_ready/data_in (input stream),
//        m_valid/m_ready/idx_out/max_out (result stream).
// Build option: define ARGMAX_RELU_EN to clamp negative inputs to 0 before compare and storage.
module argmax_6_16
  import argmax_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [IDXW-1:0] idx_out,
  output logic [T-1:0]    max_out
);

  idx_t cnt;
  idx_t best_idx;
  val_t best_val;
  val_t val_in;
  logic last;
  logic take;
  logic gt;
  logic load;
  logic full;
  res_t next_res;
  res_t res;

`ifdef ARGMAX_RELU_EN
  assign val_in = data_in[T-1] ? '0 : val_t'(data_in);
`else
  assign val_in = val_t'(data_in);
`endif

  assign last    = (cnt == LAST_IDX);
  // Only the last element needs a free output slot; it may use the slot being drained.
  assign s_ready = !last || !full || m_ready;
  assign take    = s_valid && s_ready;
  assign load    = take && last;
  // Signed, strict: equal values keep the earlier (lower) index.
  assign gt      = (val_in > best_val);

  // The final compare bypasses the running registers straight into the output register.
  always_comb begin
    next_res = '0;
    if (gt) begin
      next_res.idx = cnt;
      next_res.val = val_in;
    end else begin
      next_res.idx = best_idx;
      next_res.val = best_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (take) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (cnt == '0) begin
        best_val <= val_in;
        best_idx <= '0;
      end else if (gt) begin
        best_val <= val_in;
        best_idx <= cnt;
      end
    end
  end

  stream_out_reg u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .next_res (next_res),
    .drain    (m_ready),
    .full     (full),
    .res      (res)
  );

  assign m_valid = full;
  assign idx_out = res.idx;
  assign max_out = res.val;

endmodule

// File: tb/tb_argmax_6_16.sv
// Randomized and directed bench for argmax_6_16 with a scoreboard queue.
// An input monitor builds frames from accepted values and pushes the reference result;
// an output monitor pops and compares on every output transfer.
module tb_argmax_6_16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] data_in = '0;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  idx_out;
  logic [15:0] max_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int res_n = 0;

  logic        mr_force = 1'b1;
  logic        mr_rand = 1'b0;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  logic signed [15:0] frm[$];

  argmax_6_16 dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of m_ready: forced level or random 50%.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_force;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: argmax with lowest index on ties, optional clamp of negatives.
  function automatic exp_t ref_argmax(input logic signed [15:0] f[$]);
    exp_t r;
    logic signed [15:0] best;
    int bi;
    best = 0;
    bi = 0;
    for (int i = 0; i < f.size(); i++) begin
      logic signed [15:0] v;
      v = f[i];
`ifdef ARGMAX_RELU_EN
      if (v < 0) v = 0;
`endif
      if (i == 0 || v > best) begin
        best = v;
        bi = i;
      end
    end
    r.idx = 3'(bi);
    r.val = best;
    return r;
  endfunction

  // Input monitor: collect accepted values into frames.
  always @(negedge clk) begin
    if (!reset) begin
      frm.delete();
    end else if (s_valid && s_ready) begin
      frm.push_back(data_in);
      if (frm.size() == 6) begin
        exp_q.push_back(ref_argmax(frm));
        frm.delete();
      end
    end
  end

  // Output monitor: compare on every output transfer.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      res_n++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got idx %0d val %h, none expected", idx_out, max_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_idx", 16'(idx_out), 16'(e.idx));
        chk("sb_val", max_out, e.val);
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    data_in = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one value; returns at posedge+1 after the accepting edge.
  task automatic send_val(input logic [15:0] v);
    int w;
    w = 0;
    s_valid = 1'b1;
    data_in = v;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      w++;
      if (w > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles", w);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] a, b, c, d, e, f);
    send_val(a); send_val(b); send_val(c); send_val(d); send_val(e); send_val(f);
    s_valid = 1'b0;
    data_in = 'x;
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 16'($signed($urandom_range(0, 8)) - 4);
      1: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int c0, r0, w;
    // Reset state
    #2;
    chk("rst_m_valid", 16'(m_valid), 16'd0);
    chk("rst_idx", 16'(idx_out), 16'd0);
    chk("rst_max", max_out, 16'd0);
    chk("rst_s_ready", 16'(s_ready), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Frame 3,-1,7,7,2,-5 with latency check
    send_val(16'd3); send_val(16'hffff); send_val(16'd7);
    send_val(16'd7); send_val(16'd2);
    chk("lat_before", 16'(m_valid), 16'd0);
    send_val(16'hfffb);
    s_valid = 1'b0;
    data_in = 'x;
    chk("lat_after", 16'(m_valid), 16'd1);
    chk("f1_idx", 16'(idx_out), 16'd2);
    chk("f1_max", max_out, 16'd7);
    idle(2);

    // Frame -8,-3,-3,-9,-100,-4
    send_frame(16'hfff8, 16'hfffd, 16'hfffd, 16'hfff7, 16'hff9c, 16'hfffc);
`ifdef ARGMAX_RELU_EN
    chk("neg_idx", 16'(idx_out), 16'd0);
    chk("neg_max", max_out, 16'd0);
`else
    chk("neg_idx", 16'(idx_out), 16'd1);
    chk("neg_max", max_out, 16'hfffd);
`endif
    idle(2);

    // Six minimum values
    send_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    chk("min_idx", 16'(idx_out), 16'd0);
`ifdef ARGMAX_RELU_EN
    chk("min_max", max_out, 16'd0);
`else
    chk("min_max", max_out, 16'h8000);
`endif
    idle(2);

    // Backpressure: hold m_ready low across frame 1 completion and frame 2
    mr_force = 1'b0;
    idle(2);
    send_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    send_val(16'd9); send_val(16'd0); send_val(16'd0); send_val(16'd0); send_val(16'd0);
    s_valid = 1'b1;
    data_in = 16'd0;
    repeat (20) begin
      @(negedge clk);
      chk("bp_s_ready", 16'(s_ready), 16'd0);
      chk("bp_m_valid", 16'(m_valid), 16'd1);
      chk("bp_idx", 16'(idx_out), 16'd5);
      chk("bp_max", max_out, 16'd6);
    end
    mr_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_rdy", 16'(s_ready), 16'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    data_in = 'x;
    chk("bp_new_valid", 16'(m_valid), 16'd1);
    chk("bp_new_idx", 16'(idx_out), 16'd0);
    chk("bp_new_max", max_out, 16'd9);
    idle(3);

    // Reset mid-frame
    send_val(16'd50); send_val(16'd60); send_val(16'd70);
    s_valid = 1'b0;
    data_in = 'x;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(m_valid), 16'd0);
    chk("mid_rst_idx", 16'(idx_out), 16'd0);
    chk("mid_rst_max", max_out, 16'd0);
    chk("mid_rst_rdy", 16'(s_ready), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    r0 = res_n;
    send_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    chk("post_rst_idx", 16'(idx_out), 16'd5);
    chk("post_rst_max", max_out, 16'd6);
    idle(2);
    chk("post_rst_count", 16'(res_n - r0), 16'd1);

    // Continuous back-to-back frames
    r0 = res_n;
    c0 = cyc;
    for (int i = 0; i < 24; i++) send_val(rnd_val());
    chk("b2b_cycles", 16'(cyc - c0), 16'd24);
    idle(2);
    chk("b2b_results", 16'(res_n - r0), 16'd4);

    // Randomized valid/ready over 1250 frames
    mr_rand = 1'b1;
    for (int i = 0; i < 1250 * 6; i++) begin
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
      send_val(rnd_val());
    end
    idle(1);
    mr_rand = 1'b0;
    mr_force = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    idle(2);
    chk("drain_left", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
